// File: rtl/chip_checker_timer_pkg.sv
// Shared definitions for the interval-timer scheduler: s1 register map,
// control-word bits and the sequencing FSM states.
package chip_checker_timer_pkg;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CONTROL = 4'd1;
    localparam logic [3:0] ADDR_PERIODL = 4'd2;
    localparam logic [3:0] ADDR_PERIODH = 4'd3;
    localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
    localparam logic [3:0] ADDR_PERIOD3 = 4'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << CTRL_STOP);
    // One-shot run: CONT deliberately left clear.
    localparam logic [15:0] CTRL_RUN_WORD  = 16'((1 << CTRL_START) | (1 << CTRL_ITO) | (0 << CTRL_CONT));

    typedef enum logic [3:0] {
        S_IDLE,
        S_GRANT,
        S_W_STOP,
        S_W_P0,
        S_W_P1,
        S_W_P2,
        S_W_P3,
        S_W_CLR,
        S_W_RUN,
        S_WAIT,
        S_W_ACK,
        S_DONE,
        S_W_ABORT,
        S_ABORT_ACK
    } state_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  addr;
        logic [15:0] data;
    } s1_wr_t;

endpackage

// File: rtl/chip_checker_rr_arb.sv
// Round-robin arbiter: the most recently granted channel drops to lowest
// priority once the grant is taken (advance).
module chip_checker_rr_arb #(
    parameter int N_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CH-1:0]           req,
    input  logic                      advance,
    output logic [N_CH-1:0]           grant,
    output logic [$clog2(N_CH)-1:0]   grant_idx,
    output logic                      any_req
);

    localparam int IW = $clog2(N_CH);

    logic [IW-1:0] last_q;

    function automatic int rr_pos(input int base, input int k);
        int c;
        c = base + k;
        return (c >= N_CH) ? c - N_CH : c;
    endfunction

    // Scan from the farthest position to the nearest so the nearest hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it a
        // no-request cycle would leave them unassigned and infer latches.
        grant     = '0;
        grant_idx = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (req[rr_pos(int'(last_q), k)]) begin
                grant                          = '0;
                grant[rr_pos(int'(last_q), k)] = 1'b1;
                grant_idx                      = IW'(rr_pos(int'(last_q), k));
            end
        end
    end

    assign any_req = |req;

    // Reset to the top channel so channel 0 has first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n)
            last_q <= IW'(N_CH - 1);
        else if (advance && any_req)
            last_q <= grant_idx;
    end

endmodule

// File: rtl/chip_checker_timer_sched.sv
// Shares one Avalon interval timer among N_CH one-shot delay requesters,
// programming it over s1 and turning its irq into per-channel done pulses.
module chip_checker_timer_sched
    import chip_checker_timer_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int TICK_W = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*TICK_W-1:0]    req_ticks,
    input  logic [N_CH-1:0]           cancel,
    output logic [N_CH-1:0]           busy,
    output logic [N_CH-1:0]           done,
    output logic [$clog2(N_CH)-1:0]   active_ch,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [3:0]                tmr_address,
    output logic [15:0]               tmr_writedata,
    input  logic                      tmr_irq
);

    localparam int IW = $clog2(N_CH);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   active_oh_q, done_q;
    logic [N_CH-1:0]   arb_req, arb_grant;
    logic [IW-1:0]     active_q, arb_idx;
    logic [TICK_W-1:0] ticks_q [N_CH];
    logic [TICK_W-1:0] ticks_sel;
    logic [31:0]       load;
    logic              arb_any, take, finish, cancel_act;
    s1_wr_t            wr_d, wr_q;

    // A channel cancelled this cycle must not win the grant.
    assign arb_req    = pending_q & ~cancel;
    assign cancel_act = |(cancel & active_oh_q);
    assign ticks_sel  = ticks_q[active_q];
    assign load       = 32'(ticks_sel) - 32'd1;

    chip_checker_rr_arb #(.N_CH(N_CH)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (arb_req),
        .advance   (take),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_comb begin
        pending_d = pending_q;
        if (finish)
            pending_d = pending_d & ~active_oh_q;
        pending_d = (pending_d | (req & ~pending_q)) & ~cancel;
    end

    // NOTE: tick storage is only read after its pending bit is set, so it
    // needs no reset and can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++)
            if (req[i] && !pending_q[i] && !cancel[i])
                ticks_q[i] <= req_ticks[i*TICK_W +: TICK_W];
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE:      if (arb_any) begin state_d = S_GRANT; take = 1'b1; end
            S_GRANT: begin
                if (cancel_act)
                    state_d = S_IDLE;
                else if (ticks_sel < TICK_W'(2)) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end else
                    state_d = S_W_STOP;
            end
            S_W_STOP:    state_d = cancel_act ? S_W_ABORT : S_W_P0;
            S_W_P0:      state_d = cancel_act ? S_W_ABORT : S_W_P1;
            S_W_P1:      state_d = cancel_act ? S_W_ABORT : S_W_P2;
            S_W_P2:      state_d = cancel_act ? S_W_ABORT : S_W_P3;
            S_W_P3:      state_d = cancel_act ? S_W_ABORT : S_W_CLR;
            S_W_CLR:     state_d = cancel_act ? S_W_ABORT : S_W_RUN;
            S_W_RUN:     state_d = cancel_act ? S_W_ABORT : S_WAIT;
            S_WAIT: begin
                if (cancel_act)
                    state_d = S_W_ABORT;
                else if (tmr_irq)
                    state_d = S_W_ACK;
            end
            S_W_ACK: begin
                if (cancel_act)
                    state_d = S_IDLE;
                else begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end
            end
            S_DONE:      state_d = S_IDLE;
            S_W_ABORT:   state_d = S_ABORT_ACK;
            S_ABORT_ACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // The bus register holds the write belonging to the state being entered.
    always_comb begin
        wr_d = '0;
        case (state_d)
            S_W_STOP, S_W_ABORT:           wr_d = '{en: 1'b1, addr: ADDR_CONTROL, data: CTRL_STOP_WORD};
            S_W_P0:                        wr_d = '{en: 1'b1, addr: ADDR_PERIODL, data: load[15:0]};
            S_W_P1:                        wr_d = '{en: 1'b1, addr: ADDR_PERIODH, data: load[31:16]};
            S_W_P2:                        wr_d = '{en: 1'b1, addr: ADDR_PERIOD2, data: 16'h0000};
            S_W_P3:                        wr_d = '{en: 1'b1, addr: ADDR_PERIOD3, data: 16'h0000};
            S_W_CLR, S_W_ACK, S_ABORT_ACK: wr_d = '{en: 1'b1, addr: ADDR_STATUS,  data: 16'h0000};
            S_W_RUN:                       wr_d = '{en: 1'b1, addr: ADDR_CONTROL, data: CTRL_RUN_WORD};
            default:                       wr_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            active_q    <= '0;
            active_oh_q <= '0;
            done_q      <= '0;
            wr_q        <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wr_q      <= wr_d;
            done_q    <= finish ? active_oh_q : '0;
            if (take) begin
                active_q    <= arb_idx;
                active_oh_q <= arb_grant;
            end
        end
    end

    assign busy           = pending_q;
    assign done           = done_q;
    assign active_ch      = active_q;
    assign tmr_chipselect = wr_q.en;
    assign tmr_write_n    = ~wr_q.en;
    assign tmr_address    = wr_q.addr;
    assign tmr_writedata  = wr_q.data;

endmodule

// File: tb/tb_chip_checker_timer_sched.sv
// Bench for chip_checker_timer_sched with a behavioural interval timer on s1
// and a transaction-level scheduling model.
module tb_chip_checker_timer_sched;

    localparam int N_CH   = 4;
    localparam int TICK_W = 32;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_CH-1:0]        req = '0;
    logic [N_CH*TICK_W-1:0] req_ticks = '0;
    logic [N_CH-1:0]        cancel = '0;
    logic [N_CH-1:0]        busy, done;
    logic [1:0]             active_ch;
    logic                   tmr_chipselect, tmr_write_n, tmr_irq;
    logic [3:0]             tmr_address;
    logic [15:0]            tmr_writedata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    chip_checker_timer_sched #(.N_CH(N_CH), .TICK_W(TICK_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_ticks      (req_ticks),
        .cancel         (cancel),
        .busy           (busy),
        .done           (done),
        .active_ch      (active_ch),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_address    (tmr_address),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    // Interval timer: counts period+1 cycles after START, then sets TO and stops.
    logic [63:0] tm_period, tm_cnt;
    logic        tm_run, tm_to, tm_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tm_period <= '0; tm_cnt <= '0; tm_run <= 1'b0; tm_to <= 1'b0; tm_ito <= 1'b0;
        end else begin
            if (tm_run) begin
                if (tm_cnt == 0) begin tm_to <= 1'b1; tm_run <= 1'b0; end
                else tm_cnt <= tm_cnt - 1;
            end
            if (tmr_chipselect && !tmr_write_n) begin
                case (tmr_address)
                    4'd0: tm_to <= 1'b0;
                    4'd1: begin
                        tm_ito <= tmr_writedata[0];
                        if (tmr_writedata[3]) tm_run <= 1'b0;
                        else if (tmr_writedata[2]) begin tm_run <= 1'b1; tm_cnt <= tm_period; end
                    end
                    4'd2: tm_period[15:0]  <= tmr_writedata;
                    4'd3: tm_period[31:16] <= tmr_writedata;
                    4'd4: tm_period[47:32] <= tmr_writedata;
                    4'd5: tm_period[63:48] <= tmr_writedata;
                    default: ;
                endcase
            end
        end
    end

    assign tmr_irq = tm_to & tm_ito;

    typedef struct { int cyc; int a; int d; } wr_ev_t;
    typedef struct { int cyc; int ch; logic [N_CH-1:0] busy_now; logic [N_CH-1:0] busy_prev; } done_ev_t;

    wr_ev_t          wq[$];
    done_ev_t        dq[$];
    logic [N_CH-1:0] busy_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr_chipselect && !tmr_write_n)
                wq.push_back('{cyc: cyc, a: int'(tmr_address), d: int'(tmr_writedata)});
            for (int i = 0; i < N_CH; i++)
                if (done[i])
                    dq.push_back('{cyc: cyc, ch: i, busy_now: busy, busy_prev: busy_prev});
        end
        busy_prev = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        req = '0; cancel = '0; reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wq.delete(); dq.delete();
    endtask

    task automatic pulse_req(input int ch, input logic [31:0] t);
        @(negedge clk);
        req[ch] = 1'b1;
        req_ticks[ch*TICK_W +: TICK_W] = t;
        @(negedge clk);
        req[ch] = 1'b0;
    endtask

    task automatic pulse_cancel(input int ch);
        @(negedge clk);
        cancel[ch] = 1'b1;
        @(negedge clk);
        cancel[ch] = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k = 0;
        while (dq.size() < n && k < budget) begin @(negedge clk); k++; end
        n_tests++;
        if (dq.size() < n) begin
            n_fail++;
            $display("FAIL %s_wait: done pulses seen %0d, required %0d", tag, dq.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int quiet = 0;
        int k = 0;
        while (quiet < 4 && k < budget) begin
            @(negedge clk); k++;
            if (busy == '0 && !tmr_chipselect) quiet++; else quiet = 0;
        end
        n_tests++;
        if (quiet < 4) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b cs=%b after %0d cycles, required idle", tag, busy, tmr_chipselect, k);
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (wq.size() < n && k < budget) begin @(negedge clk); k++; end
        n_tests++;
        if (wq.size() < n) begin
            n_fail++;
            $display("FAIL %s_writes: got %0d s1 writes, required %0d", tag, wq.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, done, active_ch} !== '0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b done=%b active=%0d, required all 0", busy, done, active_ch);
        end
        n_tests++;
        if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b0, 1'b1, 4'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: cs=%b wn=%b a=%0d d=%h, required cs=0 wn=1 a=0 d=0",
                     tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== '0 || tmr_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b cs=%b, required 0 with no request", busy, tmr_chipselect);
        end
    endtask

    task automatic test_single();
        int exp_a[8] = '{1, 2, 3, 4, 5, 0, 1, 0};
        int exp_d[8] = '{8, 99, 0, 0, 0, 0, 5, 0};
        do_reset();
        pulse_req(0, 32'd100);
        n_tests++;
        if (busy !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_busy_rise: busy=%b, required 0001", busy);
        end
        wait_dones(1, 300, "single");
        n_tests++;
        if (wq.size() !== 8) begin
            n_fail++;
            $display("FAIL single_wr_count: got %0d writes, required 8", wq.size());
        end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            n_tests++;
            if (wq[i].a !== exp_a[i] || wq[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL single_wr[%0d]: got a=%0d d=%0d, required a=%0d d=%0d", i, wq[i].a, wq[i].d, exp_a[i], exp_d[i]);
            end
        end
        if (dq.size() > 0 && wq.size() > 6) begin
            n_tests++;
            if (dq[0].ch !== 0 || dq[0].cyc !== wq[6].cyc + 103) begin
                n_fail++;
                $display("FAIL single_done: got ch%0d at cycle %0d, required ch0 at cycle %0d", dq[0].ch, dq[0].cyc, wq[6].cyc + 103);
            end
            n_tests++;
            if (dq[0].busy_now[0] !== 1'b0 || dq[0].busy_prev[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL single_busy_fall: busy[0] prev=%b at_done=%b, required 1 then 0", dq[0].busy_prev[0], dq[0].busy_now[0]);
            end
        end
        wait_idle(50, "single");
    endtask

    task automatic test_round_robin();
        int exp_ch[5] = '{0, 1, 2, 3, 0};
        do_reset();
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) req_ticks[i*TICK_W +: TICK_W] = 32'd10;
        req = '1;
        @(negedge clk);
        req = '0;
        n_tests++;
        if (busy !== 4'b1111) begin
            n_fail++;
            $display("FAIL rr_busy_all: busy=%b, required 1111", busy);
        end
        wait_dones(1, 200, "rr_first");
        repeat (5) @(negedge clk);
        pulse_req(0, 32'd10);
        wait_dones(5, 500, "rr");
        for (int i = 0; i < 5 && i < dq.size(); i++) begin
            n_tests++;
            if (dq[i].ch !== exp_ch[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got ch%0d, required ch%0d", i, dq[i].ch, exp_ch[i]);
            end
        end
        wait_idle(50, "rr");
    endtask

    task automatic test_short();
        do_reset();
        pulse_req(2, 32'd0);
        wait_idle(50, "short0");
        pulse_req(2, 32'd1);
        wait_idle(50, "short1");
        n_tests++;
        if (dq.size() !== 2) begin
            n_fail++;
            $display("FAIL short_done_count: got %0d done pulses, required 2", dq.size());
        end
        for (int i = 0; i < dq.size(); i++) begin
            n_tests++;
            if (dq[i].ch !== 2) begin
                n_fail++;
                $display("FAIL short_done_ch[%0d]: got ch%0d, required ch2", i, dq[i].ch);
            end
        end
        n_tests++;
        if (wq.size() !== 0) begin
            n_fail++;
            $display("FAIL short_no_bus: got %0d s1 writes, required 0", wq.size());
        end
    endtask

    task automatic test_cancel_active();
        do_reset();
        pulse_req(1, 32'd1000);
        wait_writes(7, 50, "cancel_run");
        repeat (500) @(negedge clk);
        pulse_cancel(1);
        wait_idle(50, "cancel");
        n_tests++;
        if (dq.size() !== 0) begin
            n_fail++;
            $display("FAIL cancel_no_done: got %0d done pulses, required 0", dq.size());
        end
        n_tests++;
        if (wq.size() !== 9) begin
            n_fail++;
            $display("FAIL cancel_wr_count: got %0d writes, required 9", wq.size());
        end else begin
            n_tests++;
            if (wq[7].a !== 1 || wq[7].d !== 8 || wq[8].a !== 0 || wq[8].d !== 0) begin
                n_fail++;
                $display("FAIL cancel_abort_wr: got (%0d,%0d),(%0d,%0d), required (1,8),(0,0)", wq[7].a, wq[7].d, wq[8].a, wq[8].d);
            end
        end
        n_tests++;
        if (tm_run !== 1'b0 || tmr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_timer: run=%b irq=%b, required 0 0", tm_run, tmr_irq);
        end
        pulse_req(0, 32'd20);
        wait_dones(1, 100, "cancel_next");
        if (dq.size() > 0 && wq.size() > 15) begin
            n_tests++;
            if (dq[0].ch !== 0 || dq[0].cyc !== wq[15].cyc + 23) begin
                n_fail++;
                $display("FAIL cancel_next_done: got ch%0d at %0d, required ch0 at %0d", dq[0].ch, dq[0].cyc, wq[15].cyc + 23);
            end
        end
        wait_idle(50, "cancel_next");
    endtask

    task automatic test_cancel_irq();
        int k = 0;
        do_reset();
        pulse_req(3, 32'd30);
        while (!tmr_irq && k < 100) begin @(negedge clk); k++; end
        n_tests++;
        if (tmr_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_cancel_wait: irq=%b after %0d cycles, required 1", tmr_irq, k);
        end
        cancel[3] = 1'b1;
        @(negedge clk);
        cancel[3] = 1'b0;
        k = 1;
        while (tmr_irq && k < 3) begin @(negedge clk); k++; end
        n_tests++;
        if (tmr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_cancel_clear: irq=%b %0d cycles after cancel, required 0", tmr_irq, k);
        end
        wait_idle(50, "irq_cancel");
        n_tests++;
        if (dq.size() !== 0) begin
            n_fail++;
            $display("FAIL irq_cancel_no_done: got %0d done pulses, required 0", dq.size());
        end
    endtask

    task automatic test_wide();
        do_reset();
        pulse_req(0, 32'h0001_0000);
        wait_writes(3, 30, "wide");
        if (wq.size() >= 3) begin
            n_tests++;
            if (wq[1].a !== 2 || wq[1].d !== 32'hFFFF || wq[2].a !== 3 || wq[2].d !== 0) begin
                n_fail++;
                $display("FAIL wide_load: got (%0d,%h),(%0d,%h), required (2,ffff),(3,0000)", wq[1].a, wq[1].d, wq[2].a, wq[2].d);
            end
        end
        pulse_cancel(0);
        wait_idle(50, "wide");
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_req(1, 32'd200);
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, active_ch, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !==
            {4'h0, 4'h0, 2'd0, 1'b0, 1'b1, 4'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL midreset_out: busy=%b done=%b act=%0d cs=%b wn=%b a=%0d d=%h, required reset values",
                     busy, done, active_ch, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
        end
        n_tests++;
        if (tm_run !== 1'b0 || tmr_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_timer: run=%b irq=%b, required 0 0", tm_run, tmr_irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wq.delete(); dq.delete();
        repeat (30) @(negedge clk);
        n_tests++;
        if (wq.size() !== 0 || dq.size() !== 0 || busy !== '0) begin
            n_fail++;
            $display("FAIL midreset_quiet: writes=%0d dones=%0d busy=%b, required 0 0 0", wq.size(), dq.size(), busy);
        end
    endtask

    // Model: a batch posted together is served in round-robin order starting
    // after the last served channel; timer users see load=ticks-1 and
    // done exactly ticks+3 cycles after their START write.
    task automatic test_random();
        int last = N_CH - 1;
        int tk[N_CH];
        int exp_q[$];
        int mask, wi, ch, ld;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            wq.delete(); dq.delete(); exp_q.delete();
            mask = int'($urandom_range(1, 15));
            @(negedge clk);
            for (int i = 0; i < N_CH; i++) begin
                tk[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 60));
                req_ticks[i*TICK_W +: TICK_W] = TICK_W'(tk[i]);
            end
            req = N_CH'(mask);
            @(negedge clk);
            req = '0;
            for (int k = 1; k <= N_CH; k++) begin
                ch = (last + k) % N_CH;
                if (mask[ch]) exp_q.push_back(ch);
            end
            wait_dones(exp_q.size(), 800, "rand");
            wi = 0;
            for (int j = 0; j < exp_q.size() && j < dq.size(); j++) begin
                ch = exp_q[j];
                n_tests++;
                if (dq[j].ch !== ch) begin
                    n_fail++;
                    $display("FAIL rand_order[%0d.%0d]: got ch%0d, required ch%0d", r, j, dq[j].ch, ch);
                end
                if (tk[ch] >= 2) begin
                    ld = tk[ch] - 1;
                    n_tests++;
                    if (wi + 7 >= wq.size()) begin
                        n_fail++;
                        $display("FAIL rand_writes[%0d.%0d]: got %0d writes, required at least %0d", r, j, wq.size(), wi + 8);
                    end else begin
                        if (wq[wi+1].d !== (ld & 16'hFFFF) || wq[wi+2].d !== (ld >> 16) ||
                            dq[j].cyc !== wq[wi+6].cyc + tk[ch] + 3) begin
                            n_fail++;
                            $display("FAIL rand_timing[%0d.%0d]: ch%0d got load %h_%h done %0d, required %h done %0d",
                                     r, j, ch, wq[wi+2].d, wq[wi+1].d, dq[j].cyc, ld, wq[wi+6].cyc + tk[ch] + 3);
                        end
                    end
                    wi += 8;
                end
            end
            if (exp_q.size() > 0) last = exp_q[exp_q.size() - 1];
            wait_idle(60, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_short();
        test_cancel_active();
        test_cancel_irq();
        test_wide();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
